div_iter: RTL and testbench
===========================

# div_iter

Iterative 32-bit radix-2 divider for the execute stage of the five-stage MIPS pipeline, serving DIV and DIVU. It takes the forwarded rs/rt operands from execute, holds the pipeline with a stall request while it iterates, and delivers {hi, lo} to the HI/LO write path that travels through memory and writeback.

## Interface
Parameters:
- WIDTH, 32, operand width; the only supported value is 32.

Ports:
- clk  in  1  pipeline clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  a divide instruction is in execute. Level-sensitive; sampled only in IDLE.
- signed_i  in  1  1 = DIV, 0 = DIVU. Sampled with start_i.
- a_i  in  32  dividend (rs).
- b_i  in  32  divisor (rt).
- annul_i  in  1  execute flush; aborts any operation in progress.
- stall_o  out  1  combinational stall request to the hazard unit.
- ready_o  out  1  registered one-cycle pulse: result is valid.
- hi_o  out  32  registered remainder.
- lo_o  out  32  registered quotient.

## Operation
- States: IDLE, BUSY, ZERO, DONE.
- IDLE, start_i=1, annul_i=0, b_i≠0:
  - latch |a|, |b|, quotient sign, remainder sign;
  - clear partial remainder and count;
  - go to BUSY.
- IDLE, start_i=1, annul_i=0, b_i=0: go to ZERO.
- BUSY, one restoring step per cycle:
  - r = {r[30:0], q[31]};
  - q <<= 1;
  - if r ≥ |b|, then r -= |b| and q[0] = 1.
  - The compare uses a 33-bit subtract.
- BUSY exit: after the 32nd step (count = 31), go to DONE.
- DONE:
  - hi_o/lo_o are loaded on entry, after sign fix-up, and ready_o = 1.
  - Next state is IDLE unconditionally.
  - start_i is ignored in DONE.
- ZERO: load lo_o = 0xFFFFFFFF and hi_o = a_i, pulse ready_o, go to IDLE.
- Signed fix-up:
  - The quotient is negated when sign(a) ≠ sign(b).
  - The remainder takes the sign of a.
  - Magnitudes use 32-bit unsigned arithmetic, so |0x80000000| = 0x80000000.
  - 0x80000000 / −1 yields lo = 0x80000000, hi = 0.
- stall_o = (IDLE & start_i & ~annul_i) | BUSY | (ZERO-entry cycle). It is low in DONE, so the divide instruction advances in the cycle it sees ready_o.
- annul_i in any state forces IDLE on the next edge. No ready_o is produced, and hi_o/lo_o keep their previous values.
- hi_o/lo_o hold their values until the next completed operation.

## Timing
- Reset: state = IDLE, count = 0, ready_o = 0, hi_o = 0, lo_o = 0, stall_o = 0 (with start_i low).
- Normal latency:
  - start_i sampled in IDLE at edge 0;
  - BUSY for 32 cycles;
  - ready_o high in the 33rd cycle after edge 0.
  - stall_o is high from the start cycle through the last BUSY cycle.
- Divide-by-zero latency: ready_o high in the cycle after start_i is sampled.
- Back-to-back divides: the second start_i is sampled in the IDLE cycle right after DONE. There are no dead cycles beyond that.
- Simultaneous start_i and annul_i in IDLE: annul wins, no state change.
- rst mid-operation: returns to the reset state on the next edge, overriding annul_i and start_i.

## Structure
- Shared package (pipeline defs package):
  - the divider state enum;
  - DIV_STEPS = 32;
  - functions abs32(x, signed) and neg32(x).
- Single module div_iter; no sub-module.
- The datapath instantiates it in the execute stage. Its lo_o/hi_o feed the HI/LO pipeline registers; its stall_o is ORed into stallE/stallF/stallD.

## Test plan
- DIVU 7 / 2: ready_o at cycle 33, lo = 3, hi = 1; stall_o high for exactly 33 cycles.
- DIV −7 / 2 (0xFFFFFFF9 / 2): lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- DIVU 0xFFFFFFFF / 1: lo = 0xFFFFFFFF, hi = 0.
- DIV 100 / 0: ready_o in the next cycle, lo = 0xFFFFFFFF, hi = 100; stall_o high for one cycle.
- Start DIVU 50 / 7, then assert annul_i in BUSY cycle 10:
  - IDLE next cycle, no ready_o, outputs unchanged.
  - Then a back-to-back DIVU 50 / 7 and DIVU 9 / 3 give lo/hi = 7/1, then 3/0, each in 33 cycles.

Source files
------------

// File: rtl/div_iter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : div_iter_pkg
//  Purpose  : Shared definitions for the iterative divider in the execute
//             stage: divider state encoding, step count and the 32-bit
//             magnitude / negate helpers used by DIV and DIVU.
//  Contents : div_state_t, DIV_STEPS, abs32(), neg32()
//  Revision : 1.0  initial release
// ============================================================================
package div_iter_pkg;

    // Divider control states, two-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ZERO = 2'd2,
        ST_DONE = 2'd3
    } div_state_t;

    // One restoring step per quotient bit.
    localparam int DIV_STEPS = 32;

    // Two's-complement negate in 32-bit unsigned arithmetic.
    function automatic logic [31:0] neg32(input logic [31:0] x);
        return (~x) + 32'd1;
    endfunction

    // Magnitude of x when treated as signed; the most negative value maps
    // to itself (0x80000000), which is its correct unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] x, input logic is_signed);
        return (is_signed && x[31]) ? neg32(x) : x;
    endfunction

endpackage : div_iter_pkg
`default_nettype wire

// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
//  Module   : div_iter
//  Purpose  : Iterative radix-2 restoring divider for DIV / DIVU in the
//             execute stage. Requests a pipeline stall while iterating and
//             delivers remainder (hi) and quotient (lo) to the HI/LO path.
//  Ports    : clk, rst        clock, synchronous active-high reset
//             start_i         divide instruction present (sampled in IDLE)
//             signed_i        1 = DIV, 0 = DIVU
//             a_i, b_i        dividend (rs), divisor (rt)
//             annul_i         execute flush, aborts any operation
//             stall_o         combinational stall request
//             ready_o         registered one-cycle result-valid pulse
//             hi_o, lo_o      registered remainder / quotient
//  Revision : 1.0  initial release
// ============================================================================
module div_iter
    import div_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             annul_i,
    output logic             stall_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam logic [4:0] c_last_step = 5'(DIV_STEPS - 1);

    div_state_t  r_state;
    div_state_t  w_next;

    logic [31:0] r_rem;       // partial remainder
    logic [31:0] r_quo;       // dividend shifting out / quotient shifting in
    logic [31:0] r_div;       // divisor magnitude
    logic [4:0]  r_count;
    logic        r_quo_neg;
    logic        r_rem_neg;
    logic        r_ready;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_accept;
    logic        w_b_zero;
    logic        w_last;
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic [31:0] w_rem_next;
    logic [31:0] w_quo_next;

    assign w_accept = start_i & ~annul_i;
    assign w_b_zero = (b_i == '0);
    assign w_last   = (r_count == c_last_step);

    // Restoring step. The shifted remainder is below 2*|b|, so a 33-bit
    // subtract suffices: bit 32 of the difference is set exactly when the
    // shifted remainder is smaller than the divisor.
    assign w_shift    = {r_rem, r_quo[31]};
    assign w_diff     = w_shift - {1'b0, r_div};
    assign w_rem_next = w_diff[32] ? w_shift[31:0] : w_diff[31:0];
    assign w_quo_next = {r_quo[30:0], ~w_diff[32]};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = w_b_zero ? ST_ZERO : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (annul_i) begin
                    w_next = ST_IDLE;
                end else if (w_last) begin
                    w_next = ST_DONE;
                end
            end
            ST_ZERO: w_next = ST_IDLE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: stall is dropped in DONE/ZERO so the divide advances
    // in the same cycle that ready_o is seen.
    // ------------------------------------------------------------------
    always_comb begin
        stall_o = 1'b0;
        case (r_state)
            ST_IDLE: stall_o = w_accept;
            ST_BUSY: stall_o = 1'b1;
            default: stall_o = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered results
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem     <= '0;
            r_quo     <= '0;
            r_div     <= '0;
            r_count   <= '0;
            r_quo_neg <= 1'b0;
            r_rem_neg <= 1'b0;
            r_ready   <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_b_zero) begin
                            // Divide by zero: all-ones quotient, dividend as remainder.
                            r_lo    <= 32'hFFFF_FFFF;
                            r_hi    <= a_i;
                            r_ready <= 1'b1;
                        end else begin
                            r_quo     <= abs32(a_i, signed_i);
                            r_div     <= abs32(b_i, signed_i);
                            r_rem     <= '0;
                            r_count   <= '0;
                            r_quo_neg <= signed_i & (a_i[31] ^ b_i[31]);
                            r_rem_neg <= signed_i & a_i[31];
                        end
                    end
                end
                ST_BUSY: begin
                    if (!annul_i) begin
                        r_rem   <= w_rem_next;
                        r_quo   <= w_quo_next;
                        r_count <= r_count + 5'd1;
                        if (w_last) begin
                            r_lo    <= r_quo_neg ? neg32(w_quo_next) : w_quo_next;
                            r_hi    <= r_rem_neg ? neg32(w_rem_next) : w_rem_next;
                            r_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ready_o = r_ready;
    assign hi_o    = r_hi;
    assign lo_o    = r_lo;

endmodule : div_iter
`default_nettype wire

// File: tb/tb_div_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div_iter
//  Purpose  : Directed self-checking bench for div_iter with hand-computed
//             quotient, remainder, latency and stall-length expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_div_iter;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        annul_i;
    logic        stall_o;
    logic        ready_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_checks;
    int n_fail;

    div_iter #(.WIDTH(32)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .signed_i (signed_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .annul_i  (annul_i),
        .stall_o  (stall_o),
        .ready_o  (ready_o),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one divide in the current IDLE cycle and follow it to ready_o.
    // Latency is counted in cycles after the start cycle; stall length
    // counts the start cycle plus every BUSY cycle.
    task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_lo,
                          input logic [31:0] exp_hi, input int exp_lat);
        int cycles;
        int stalls;
        @(negedge clk);
        start_i  = 1'b1;
        signed_i = sgn;
        a_i      = a;
        b_i      = b;
        annul_i  = 1'b0;
        #1;
        check({tag, ".ready_idle"}, 32'(ready_o), 32'd0);
        cycles = 0;
        stalls = 0;
        while (!ready_o && cycles < 100) begin
            if (stall_o) stalls++;
            @(negedge clk);
            start_i = 1'b0;
            #1;
            cycles++;
        end
        check({tag, ".latency"}, 32'(cycles), 32'(exp_lat));
        check({tag, ".stall_len"}, 32'(stalls), 32'(exp_lat));
        check({tag, ".stall_done"}, 32'(stall_o), 32'd0);
        check({tag, ".lo"}, lo_o, exp_lo);
        check({tag, ".hi"}, hi_o, exp_hi);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start_i  = 1'b0;
        signed_i = 1'b0;
        a_i      = '0;
        b_i      = '0;
        annul_i  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset.ready", 32'(ready_o), 32'd0);
        check("reset.stall", 32'(stall_o), 32'd0);
        check("reset.hi", hi_o, 32'd0);
        check("reset.lo", lo_o, 32'd0);

        do_div("divu_7_2",      1'b0, 32'd7,          32'd2,          32'd3,          32'd1,          33);
        do_div("div_m7_2",      1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  33);
        do_div("div_min_m1",    1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33);
        do_div("divu_max_1",    1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          33);
        do_div("div_100_0",     1'b1, 32'd100,        32'd0,          32'hFFFF_FFFF,  32'd100,        1);

        // Abort DIVU 50/7 in BUSY cycle 10.
        @(negedge clk);
        start_i  = 1'b1;
        signed_i = 1'b0;
        a_i      = 32'd50;
        b_i      = 32'd7;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        #1;
        check("annul.stall_idle", 32'(stall_o), 32'd0);
        check("annul.ready", 32'(ready_o), 32'd0);
        begin
            int seen_ready;
            seen_ready = 0;
            for (int i = 0; i < 40; i++) begin
                if (ready_o) seen_ready++;
                @(negedge clk);
                #1;
            end
            check("annul.no_ready", 32'(seen_ready), 32'd0);
        end
        check("annul.hi_kept", hi_o, 32'd100);
        check("annul.lo_kept", lo_o, 32'hFFFF_FFFF);

        do_div("b2b_50_7",      1'b0, 32'd50,         32'd7,          32'd7,          32'd1,          33);
        do_div("b2b_9_3",       1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          33);

        // Simultaneous start and annul in IDLE: nothing happens.
        @(negedge clk);
        start_i = 1'b1;
        annul_i = 1'b1;
        a_i     = 32'd20;
        b_i     = 32'd4;
        #1;
        check("start_annul.stall", 32'(stall_o), 32'd0);
        @(negedge clk);
        start_i = 1'b0;
        annul_i = 1'b0;
        #1;
        check("start_annul.stall_after", 32'(stall_o), 32'd0);
        check("start_annul.ready", 32'(ready_o), 32'd0);

        do_div("div_7_m2",      1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          33);

        // Reset mid-operation overrides start and annul.
        @(negedge clk);
        start_i  = 1'b1;
        signed_i = 1'b0;
        a_i      = 32'd1000;
        b_i      = 32'd3;
        repeat (5) @(negedge clk);
        rst     = 1'b1;
        annul_i = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        annul_i = 1'b0;
        start_i = 1'b0;
        #1;
        check("midrst.stall", 32'(stall_o), 32'd0);
        check("midrst.ready", 32'(ready_o), 32'd0);
        check("midrst.hi", hi_o, 32'd0);
        check("midrst.lo", lo_o, 32'd0);

        do_div("post_rst_1000_3", 1'b0, 32'd1000,     32'd3,          32'd333,        32'd1,          33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_div_iter
`default_nettype wire
